// File: rtl/alu_seq_n_bits.sv
// ============================================================================
// Module      : alu_seq_n_bits
// Description : Registered N-bit ALU with valid/ready handshakes on both sides
//               and an iterative shift-add unsigned multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_n_bits #(
    parameter int N      = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUControl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] RESULT,
    output logic [3:0]   Flags,
    output logic         illegal
);

    localparam int              c_sw       = $clog2(N);
    localparam logic [c_sw-1:0] c_cnt_last = c_sw'(N - 1);

    localparam logic [3:0] c_op_add = 4'b0000;
    localparam logic [3:0] c_op_sub = 4'b0001;
    localparam logic [3:0] c_op_and = 4'b0010;
    localparam logic [3:0] c_op_or  = 4'b0011;
    localparam logic [3:0] c_op_xor = 4'b0100;
    localparam logic [3:0] c_op_not = 4'b0101;
    localparam logic [3:0] c_op_asl = 4'b0110;
    localparam logic [3:0] c_op_asr = 4'b0111;
    localparam logic [3:0] c_op_lsl = 4'b1000;
    localparam logic [3:0] c_op_lsr = 4'b1001;
    localparam logic [3:0] c_op_mul = 4'b1010;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [c_sw-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;

    logic [c_sw-1:0]  w_shamt;
    logic [N:0]       w_sum;
    logic [N:0]       w_diff;
    logic [N:0]       w_shl;
    logic [N:0]       w_shr;
    logic [N:0]       w_sar;
    logic [N-1:0]     w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_alu_ill;
    logic [3:0]       w_alu_flags;
    logic [2*N-1:0]   w_acc_step;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_drain;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign RESULT    = result_q;
    assign Flags     = flags_q;
    assign illegal   = illegal_q;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid_q && out_ready;
    assign w_is_mul = MUL_EN && (ALUControl == c_op_mul);

    // One guard bit beyond the result catches the last bit shifted out.
    assign w_shamt = B[c_sw-1:0];
    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
    assign w_shl   = {1'b0, A} << w_shamt;
    assign w_shr   = {A, 1'b0} >> w_shamt;
    assign w_sar   = $signed({A, 1'b0}) >>> w_shamt;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_ill = 1'b0;
        case (ALUControl)
            c_op_add: begin
                w_alu_res = w_sum[N-1:0];
                w_alu_c   = w_sum[N];
                w_alu_v   = (A[N-1] == B[N-1]) && (w_sum[N-1] != A[N-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff[N-1:0];
                w_alu_c   = w_diff[N];
                w_alu_v   = (A[N-1] != B[N-1]) && (w_diff[N-1] != A[N-1]);
            end
            c_op_and: w_alu_res = A & B;
            c_op_or:  w_alu_res = A | B;
            c_op_xor: w_alu_res = A ^ B;
            c_op_not: w_alu_res = ~A;
            c_op_asl, c_op_lsl: begin
                w_alu_res = w_shl[N-1:0];
                w_alu_c   = w_shl[N];
            end
            c_op_asr: begin
                w_alu_res = w_sar[N:1];
                w_alu_c   = w_sar[0];
            end
            c_op_lsr: begin
                w_alu_res = w_shr[N:1];
                w_alu_c   = w_shr[0];
            end
            c_op_mul: w_alu_ill = !MUL_EN;
            default:  w_alu_ill = 1'b1;
        endcase
        if (w_alu_ill) begin
            w_alu_res   = '0;
            w_alu_flags = 4'b0100;
        end else begin
            w_alu_flags = {w_alu_res[N-1], (w_alu_res == '0), w_alu_c, w_alu_v};
        end
    end

    assign w_acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;

        if (w_drain) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        mcand_d  = {{N{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = w_alu_res;
                        flags_d     = w_alu_flags;
                        illegal_d   = w_alu_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = w_acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_cnt_last) begin
                    result_d    = w_acc_step[N-1:0];
                    flags_d     = {w_acc_step[N-1], (w_acc_step[N-1:0] == '0),
                                   |w_acc_step[2*N-1:N], 1'b0};
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_n_bits.sv
// ============================================================================
// Module      : tb_alu_seq_n_bits
// Description : Vector table plus handshake/multiply corner sequences, N=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_n_bits;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   ALUControl = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] RESULT;
    logic [3:0]   Flags;
    logic         illegal;

    always #5 clk = ~clk;

    alu_seq_n_bits #(.N(N), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .RESULT(RESULT), .Flags(Flags), .illegal(illegal)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         ill;
        int           lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         ill;
        int           lat;
        int           acc_cyc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t stage;
    bit   acc_flag = 0;
    bit   lat_done = 0;
    bit   hold_pend = 0;
    logic [N-1:0] h_res;
    logic [3:0]   h_flg;
    logic         h_ill;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [3:0] op, input logic [N-1:0] res,
                                input logic [3:0] flg, input logic ill, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Sampled once per cycle on the falling edge: pops/compares drained
    // results, pushes the staged expectation on every accepted input.
    task automatic monitor();
        exp_t e;
        cyc++;
        if (!rst_n) begin
            hold_pend = 0;
            lat_done  = 0;
            return;
        end
        if (hold_pend)
            chk(out_valid && RESULT == h_res && Flags == h_flg && illegal == h_ill, "hold",
                {out_valid, illegal, Flags, RESULT}, {1'b1, h_ill, h_flg, h_res});
        if (out_valid && !lat_done) begin
            if (sb.size() == 0)
                chk(1'b0, "unexpected_valid", {illegal, Flags, RESULT}, 0);
            else
                chk(cyc - sb[0].acc_cyc == sb[0].lat, "latency",
                    cyc - sb[0].acc_cyc, sb[0].lat);
            lat_done = 1;
        end
        if (out_valid && out_ready) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(RESULT == e.res && Flags == e.flg && illegal == e.ill, "result",
                    {illegal, Flags, RESULT}, {e.ill, e.flg, e.res});
            end
            lat_done = 0;
        end
        if (in_valid && in_ready) begin
            stage.acc_cyc = cyc;
            sb.push_back(stage);
            acc_flag = 1;
        end
        hold_pend = out_valid && !out_ready;
        h_res = RESULT;
        h_flg = Flags;
        h_ill = illegal;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        A = v.a; B = v.b; ALUControl = v.op;
        stage.res = v.res; stage.flg = v.flg; stage.ill = v.ill; stage.lat = v.lat;
    endtask

    task automatic wait_accept();
        acc_flag = 0;
        for (int i = 0; i < 50 && !acc_flag; i++) cycle();
        if (!acc_flag) chk(1'b0, "accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) cycle();
        if (sb.size() != 0) chk(1'b0, "drain_timeout", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              A      B      op       RESULT flags   ill lat
        tbl.push_back(mk(8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1001, 0, 1)); // 0 add overflow
        tbl.push_back(mk(8'h05, 8'h05, 4'b0001, 8'h00, 4'b0110, 0, 1)); // 1 sub equal
        tbl.push_back(mk(8'h03, 8'h05, 4'b0001, 8'hFE, 4'b1000, 0, 1)); // 2 sub borrow
        tbl.push_back(mk(8'h81, 8'h01, 4'b1001, 8'h40, 4'b0010, 0, 1)); // 3 lsr
        tbl.push_back(mk(8'h80, 8'h03, 4'b0111, 8'hF0, 4'b1000, 0, 1)); // 4 asr
        tbl.push_back(mk(8'h10, 8'h10, 4'b1010, 8'h00, 4'b0110, 0, 9)); // 5 mul
        tbl.push_back(mk(8'h12, 8'h34, 4'b1100, 8'h00, 4'b0100, 1, 1)); // 6 illegal
        tbl.push_back(mk(8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0110, 0, 1));
        tbl.push_back(mk(8'h80, 8'h01, 4'b0001, 8'h7F, 4'b0011, 0, 1));
        tbl.push_back(mk(8'hF0, 8'h3C, 4'b0010, 8'h30, 4'b0000, 0, 1));
        tbl.push_back(mk(8'h0F, 8'h80, 4'b0011, 8'h8F, 4'b1000, 0, 1));
        tbl.push_back(mk(8'hAA, 8'hFF, 4'b0100, 8'h55, 4'b0000, 0, 1));
        tbl.push_back(mk(8'h55, 8'h00, 4'b0101, 8'hAA, 4'b1000, 0, 1));
        tbl.push_back(mk(8'h81, 8'h01, 4'b0110, 8'h02, 4'b0010, 0, 1));
        tbl.push_back(mk(8'h01, 8'h08, 4'b1000, 8'h01, 4'b0000, 0, 1));
        tbl.push_back(mk(8'h03, 8'h07, 4'b1000, 8'h80, 4'b1010, 0, 1));
        tbl.push_back(mk(8'h01, 8'h01, 4'b1001, 8'h00, 4'b0110, 0, 1));
        tbl.push_back(mk(8'h7F, 8'h07, 4'b0111, 8'h00, 4'b0110, 0, 1));
        tbl.push_back(mk(8'h0F, 8'h0F, 4'b1010, 8'hE1, 4'b1000, 0, 9));
        tbl.push_back(mk(8'hFF, 8'hFF, 4'b1010, 8'h01, 4'b0010, 0, 9));
        tbl.push_back(mk(8'hFF, 8'hFF, 4'b1011, 8'h00, 4'b0100, 1, 1));
        tbl.push_back(mk(8'h01, 8'h02, 4'b1111, 8'h00, 4'b0100, 1, 1));

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(RESULT == 0 && Flags == 0 && illegal == 0 && out_valid == 0, "reset_state",
            {out_valid, illegal, Flags, RESULT}, 0);
        rst_n = 1'b1;
        cycle();
        chk(in_ready == 1'b1, "ready_after_reset", in_ready, 1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Consumer stall, then drain+accept back-to-back with no bubble
        out_ready = 1'b0;
        drive(tbl[0]);
        in_valid = 1'b1;
        wait_accept();
        drive(tbl[1]);
        for (int i = 0; i < 5; i++) begin
            chk(out_valid && !in_ready, "stall", {out_valid, in_ready}, 2'b10);
            cycle();
        end
        chk(sb.size() == 1, "no_accept_while_stalled", sb.size(), 1);
        out_ready = 1'b1;
        acc_flag  = 0;
        cycle();
        chk(acc_flag == 1'b1, "drain_and_accept", acc_flag, 1);
        drive(tbl[2]);
        chk(out_valid == 1'b1, "no_bubble", out_valid, 1);
        cycle();
        drive(tbl[3]);
        chk(out_valid == 1'b1, "no_bubble", out_valid, 1);
        cycle();
        in_valid = 1'b0;
        chk(out_valid == 1'b1, "no_bubble", out_valid, 1);
        wait_drain();

        // Multiply timing: busy for 8 cycles, result in cycle 9
        drive(tbl[5]);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        A = 8'hFF; B = 8'hFF; ALUControl = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            chk(!in_ready && !out_valid, "mul_busy", {in_ready, out_valid}, 0);
            cycle();
        end
        chk(out_valid && in_ready, "mul_done", {out_valid, in_ready}, 2'b11);
        wait_drain();

        // Reset during multiply cycle 4 aborts with no result
        run_vec(tbl[0]);
        drive(tbl[19]);
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk(RESULT == 0 && Flags == 0 && illegal == 0 && out_valid == 0, "abort_reset",
            {out_valid, illegal, Flags, RESULT}, 0);
        sb.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();
        chk(!out_valid && in_ready && RESULT == 0, "no_result_after_abort",
            {out_valid, in_ready, RESULT}, {1'b0, 1'b1, 8'h00});

        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
